// File: rtl/lcd_frame_controller_if.sv
// SDRAM pixel read bus between the LCD frame controller and the frame store.
// master: issues oREAD_SDRAM_EN, receives iREAD_DATA RD_LAT cycles later.
interface lcd_frame_controller_if;
  logic        oREAD_SDRAM_EN;
  logic [31:0] iREAD_DATA;

  modport master (
    output oREAD_SDRAM_EN,
    input  iREAD_DATA
  );

  modport slave (
    input  oREAD_SDRAM_EN,
    output iREAD_DATA
  );
endinterface

// File: rtl/lcd_frame_controller.sv
// LCD raster timing, source select (SDRAM/overlay/bars/solid) and load FSM.
// Ports: iCLK/iRST_n, iLoading/iMode/iSolid/iOVL_DATA in, sdram bus, video out.
module lcd_frame_controller #(
  parameter int H_ACTIVE = 800,
  parameter int H_BLANK  = 46,
  parameter int H_FP     = 210,
  parameter int V_ACTIVE = 480,
  parameter int V_BLANK  = 23,
  parameter int V_FP     = 22,
  parameter int PIX_W    = 8,
  parameter int RD_LAT   = 1
) (
  input  logic                 iCLK,
  input  logic                 iRST_n,
  input  logic                 iLoading,
  input  logic [1:0]           iMode,
  input  logic [3*PIX_W-1:0]   iSolid,
  input  logic [3*PIX_W-1:0]   iOVL_DATA,
  lcd_frame_controller_if.master sdram,
  output logic [10:0]          oX,
  output logic [9:0]           oY,
  output logic                 oNewFrame,
  output logic                 oEndFrame,
  output logic                 oHD,
  output logic                 oVD,
  output logic [PIX_W-1:0]     oLCD_R,
  output logic [PIX_W-1:0]     oLCD_G,
  output logic [PIX_W-1:0]     oLCD_B,
  output logic [1:0]           oState,
  output logic [15:0]          oFrameCnt
);

  localparam int H_LINE = H_BLANK + H_ACTIVE + H_FP;
  localparam int V_LINE = V_BLANK + V_ACTIVE + V_FP;

  localparam logic [10:0] H_LAST = 11'(H_LINE - 1);
  localparam logic [10:0] H_ON   = 11'(H_BLANK);
  localparam logic [10:0] H_OFF  = 11'(H_BLANK + H_ACTIVE);
  localparam logic [10:0] H_END  = 11'(H_BLANK + H_ACTIVE - 1);
  localparam logic [10:0] LAT    = 11'(RD_LAT);
  localparam logic [10:0] BAR_W  = 11'(H_ACTIVE / 8);

  localparam logic [9:0] V_LAST = 10'(V_LINE - 1);
  localparam logic [9:0] V_ON   = 10'(V_BLANK);
  localparam logic [9:0] V_OFF  = 10'(V_BLANK + V_ACTIVE);
  localparam logic [9:0] V_END  = 10'(V_BLANK + V_ACTIVE - 1);

  localparam logic [PIX_W-1:0] FULL = '1;
  localparam logic [PIX_W-1:0] HALF = PIX_W'(1 << (PIX_W - 1));

  typedef enum logic [1:0] {
    NO_DATA = 2'd0,
    LOADING = 2'd1,
    RUN     = 2'd2
  } state_t;

  typedef struct packed {
    logic               hd;
    logic               vd;
    logic [3*PIX_W-1:0] pix;
  } vid_t;

  localparam vid_t VID_RST = '{hd: 1'b0, vd: 1'b1, pix: '0};

  state_t state;
  state_t state_nx;

  logic [1:0]         mode;
  logic               new_frame;
  logic               h_act;
  logic               v_act;
  logic               act;
  logic [10:0]        x_req;
  logic               req_h;
  logic [10:0]        px;
  logic [10:0]        bar;
  logic [2:0]         bar_rgb;
  logic [3*PIX_W-1:0] bar_pix;
  logic [3*PIX_W-1:0] rd_pix;
  logic [3*PIX_W-1:0] pix;
  vid_t               s1;
  vid_t               s2;
  logic               unused_rd;

  // raster counters
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      oX <= '0;
      oY <= '0;
    end else if (oX == H_LAST) begin
      oX <= '0;
      oY <= (oY == V_LAST) ? '0 : oY + 10'd1;
    end else begin
      oX <= oX + 11'd1;
    end
  end

  assign new_frame = (oX == '0) && (oY == '0);
  assign oNewFrame = new_frame;
  assign oEndFrame = (oX == H_END) && (oY == V_END);

  assign h_act = (oX >= H_ON) && (oX < H_OFF);
  assign v_act = (oY >= V_ON) && (oY < V_OFF);
  assign act   = h_act && v_act;

  // request leads the pixel by the read latency
  assign x_req = oX + LAT;
  assign req_h = (x_req >= H_ON) && (x_req < H_OFF);

  // mode and frame count only move at frame start
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      mode      <= 2'd0;
      oFrameCnt <= '0;
    end else if (new_frame) begin
      mode      <= iMode;
      oFrameCnt <= oFrameCnt + 16'd1;
    end
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) state <= NO_DATA;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      NO_DATA: if (iLoading) state_nx = LOADING;
      LOADING: if (!iLoading && new_frame) state_nx = RUN;
      RUN:     if (iLoading && new_frame) state_nx = LOADING;
      default: state_nx = NO_DATA;
    endcase
  end

  always_comb begin
    oState               = state;
    sdram.oREAD_SDRAM_EN = (state == RUN) && (mode == 2'd0)
                           && req_h && v_act;
  end

  // bar index b: R=!b[1], G=!b[2], B=!b[0] gives W,Y,C,G,M,R,B,K
  assign px      = oX - H_ON;
  assign bar     = px / BAR_W;
  assign bar_rgb = (bar < 11'd8) ? {~bar[1], ~bar[2], ~bar[0]} : 3'b000;
  assign bar_pix = {{PIX_W{bar_rgb[2]}},
                    {PIX_W{bar_rgb[1]}},
                    {PIX_W{bar_rgb[0]}}};

  // MSB-aligned channels: keep the top PIX_W bits of each byte
  assign rd_pix = {sdram.iREAD_DATA[23 -: PIX_W],
                   sdram.iREAD_DATA[15 -: PIX_W],
                   sdram.iREAD_DATA[7 -: PIX_W]};
  assign unused_rd = ^sdram.iREAD_DATA;

  always_comb begin
    pix = '0;
    if (act) begin
      case (state)
        NO_DATA: pix = {3{FULL}};
        LOADING: pix = {3{HALF}};
        RUN: begin
          case (mode)
            2'd0:    pix = rd_pix;
            2'd1:    pix = iOVL_DATA;
            2'd2:    pix = bar_pix;
            default: pix = iSolid;
          endcase
        end
        default: pix = '0;
      endcase
    end
  end

  // two-stage video pipe keeps sync and colour aligned
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      s1 <= VID_RST;
      s2 <= VID_RST;
    end else begin
      s1.hd  <= (oX != '0);
      s1.vd  <= (oY != '0);
      s1.pix <= pix;
      s2     <= s1;
    end
  end

  assign oHD    = s2.hd;
  assign oVD    = s2.vd;
  assign oLCD_R = s2.pix[3*PIX_W-1 -: PIX_W];
  assign oLCD_G = s2.pix[2*PIX_W-1 -: PIX_W];
  assign oLCD_B = s2.pix[PIX_W-1 -: PIX_W];

endmodule

// File: tb/tb_lcd_frame_controller.sv
// Bench for lcd_frame_controller: raster model, SDRAM responder, directed runs.
// Short vertical timing keeps each frame at 6336 cycles.
module tb_lcd_frame_controller;

  localparam int HA = 800;
  localparam int HB = 46;
  localparam int HF = 210;
  localparam int VA = 3;
  localparam int VB = 2;
  localparam int VF = 1;
  localparam int RL = 3;
  localparam int HL = HA + HB + HF;
  localparam int VL = VA + VB + VF;
  localparam int FRAME = HL * VL;

  localparam logic [23:0] BARS [8] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

  logic        iCLK = 1'b0;
  logic        iRST_n = 1'b0;
  logic        iLoading = 1'b0;
  logic [1:0]  iMode = 2'd0;
  logic [23:0] iSolid = 24'h123456;
  logic [23:0] iOVL_DATA;
  logic [10:0] oX;
  logic [9:0]  oY;
  logic        oNewFrame;
  logic        oEndFrame;
  logic        oHD;
  logic        oVD;
  logic [7:0]  oLCD_R;
  logic [7:0]  oLCD_G;
  logic [7:0]  oLCD_B;
  logic [1:0]  oState;
  logic [15:0] oFrameCnt;

  int checks = 0;
  int failures = 0;

  lcd_frame_controller_if sdram_bus ();

  lcd_frame_controller #(
    .H_ACTIVE(HA), .H_BLANK(HB), .H_FP(HF),
    .V_ACTIVE(VA), .V_BLANK(VB), .V_FP(VF),
    .PIX_W(8), .RD_LAT(RL)
  ) dut (
    .iCLK(iCLK),
    .iRST_n(iRST_n),
    .iLoading(iLoading),
    .iMode(iMode),
    .iSolid(iSolid),
    .iOVL_DATA(iOVL_DATA),
    .sdram(sdram_bus),
    .oX(oX),
    .oY(oY),
    .oNewFrame(oNewFrame),
    .oEndFrame(oEndFrame),
    .oHD(oHD),
    .oVD(oVD),
    .oLCD_R(oLCD_R),
    .oLCD_G(oLCD_G),
    .oLCD_B(oLCD_B),
    .oState(oState),
    .oFrameCnt(oFrameCnt)
  );

  always #5 iCLK = ~iCLK;

  function automatic logic [23:0] ovl(int x, int y);
    logic [7:0] a;
    logic [7:0] b;
    a = 8'(x);
    b = 8'(y) + 8'h40;
    return {a, b, a ^ 8'hA5};
  endfunction

  assign iOVL_DATA = ovl(int'(oX), int'(oY));

  // SDRAM responder: data valid RL cycles after a request, junk otherwise
  logic [RL-1:0] rq;
  always @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) rq <= '0;
    else         rq <= {rq[RL-2:0], sdram_bus.oREAD_SDRAM_EN};
  end
  assign sdram_bus.iREAD_DATA = rq[RL-1] ? 32'h00AABBCC : 32'hDEADBEEF;

  function automatic bit in_act(int x, int y);
    return x >= HB && x < HB + HA && y >= VB && y < VB + VA;
  endfunction

  function automatic logic [23:0] colour(int x, int y, int st, int md);
    int p;
    int w;
    if (!in_act(x, y)) return 24'h0;
    if (st == 0) return 24'hFFFFFF;
    if (st == 1) return 24'h808080;
    if (md == 0) return 24'hAABBCC;
    if (md == 1) return ovl(x, y);
    if (md == 3) return iSolid;
    p = x - HB;
    w = HA / 8;
    for (int b = 0; b < 8; b++)
      if (p >= b * w && p < (b + 1) * w) return BARS[b];
    return 24'h0;
  endfunction

  // behavioural model
  int          mx, my, mst, mmode, since;
  logic [15:0] mcnt;
  logic [25:0] e1, e2;

  always @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      mx <= 0; my <= 0; mst <= 0; mmode <= 0;
      mcnt <= 16'd0; since <= 0;
      e1 <= '0; e2 <= '0;
    end else begin
      e1 <= {mx != 0, my != 0, colour(mx, my, mst, mmode)};
      e2 <= e1;
      since <= since + 1;
      if (mx == 0 && my == 0) begin
        mmode <= int'(iMode);
        mcnt <= mcnt + 16'd1;
      end
      case (mst)
        0: if (iLoading) mst <= 1;
        1: if (!iLoading && mx == 0 && my == 0) mst <= 2;
        default: if (iLoading && mx == 0 && my == 0) mst <= 1;
      endcase
      mx <= (mx + 1) % HL;
      if (mx == HL - 1) my <= (my + 1) % VL;
    end
  end

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 20)
        $display("FAIL %s actual=%0h required=%0h t=%0t", n, act, exp, $time);
    end
  endtask

  // per-cycle compare plus period / request measurements
  int  cyc = 0;
  int  hd_last = -1, hd_period = 0;
  int  vd_last = -1, vd_period = 0;
  bit  prev_hd = 1'b0, prev_vd = 1'b0;
  int  req_n = 0, req_first = -1;

  always @(negedge iCLK) begin
    cyc++;
    if (iRST_n) begin
      chk("oX", oX, mx);
      chk("oY", oY, my);
      chk("oNewFrame", oNewFrame, mx == 0 && my == 0);
      chk("oEndFrame", oEndFrame, mx == HB + HA - 1 && my == VB + VA - 1);
      chk("oREAD_SDRAM_EN", sdram_bus.oREAD_SDRAM_EN,
          mst == 2 && mmode == 0 && in_act(mx + RL, my));
      chk("oState", oState, mst);
      chk("oFrameCnt", oFrameCnt, mcnt);
      if (since >= 2) begin
        chk("oHD", oHD, e2[25]);
        chk("oVD", oVD, e2[24]);
        chk("oLCD", {oLCD_R, oLCD_G, oLCD_B}, e2[23:0]);
      end
      if (!oHD && prev_hd) begin
        if (hd_last >= 0) hd_period = cyc - hd_last;
        hd_last = cyc;
      end
      if (!oVD && prev_vd) begin
        if (vd_last >= 0) vd_period = cyc - vd_last;
        vd_last = cyc;
      end
      if (oX == 0) req_n = 0;
      if (sdram_bus.oREAD_SDRAM_EN) begin
        if (req_n == 0) req_first = int'(oX);
        req_n++;
      end
    end
    prev_hd = oHD;
    prev_vd = oVD;
  end

  task automatic wait_pos(int x, int y);
    int n;
    n = 0;
    do begin
      @(negedge iCLK);
      n++;
    end while (!(int'(oX) == x && int'(oY) == y) && n < 3 * FRAME);
    if (n >= 3 * FRAME) begin
      checks++;
      failures++;
      $display("FAIL wait_pos timeout x=%0d y=%0d actual=%0d,%0d", x, y, oX, oY);
    end
  endtask

  initial begin
    repeat (3) @(negedge iCLK);
    chk("rst_oX", oX, 0);
    chk("rst_oY", oY, 0);
    chk("rst_oHD", oHD, 0);
    chk("rst_oVD", oVD, 1);
    chk("rst_lcd", {oLCD_R, oLCD_G, oLCD_B}, 0);
    chk("rst_req", sdram_bus.oREAD_SDRAM_EN, 0);
    chk("rst_state", oState, 0);
    chk("rst_cnt", oFrameCnt, 0);

    iRST_n = 1'b1;
    chk("rel_oX", oX, 0);
    chk("rel_oY", oY, 0);

    wait_pos(HB + 12, VB + 1);
    chk("white_R", oLCD_R, 8'hFF);
    while (since < 2 * FRAME) @(negedge iCLK);
    chk("frames2_cnt", oFrameCnt, 2);
    chk("hd_period", hd_period, 1056);
    chk("vd_period", vd_period, 6336);
    chk("nodata_state", oState, 0);

    iMode = 2'd0;
    wait_pos(300, VB + 1);
    iLoading = 1'b1;
    @(negedge iCLK);
    chk("load_state", oState, 1);
    repeat (9) @(negedge iCLK);
    iLoading = 1'b0;
    repeat (2) @(negedge iCLK);
    chk("grey_G", oLCD_G, 8'h80);
    wait_pos(0, 0);
    @(negedge iCLK);
    chk("run_state", oState, 2);

    wait_pos(HB + 100, VB);
    chk("sdram_R", oLCD_R, 8'hAA);
    chk("sdram_G", oLCD_G, 8'hBB);
    chk("sdram_B", oLCD_B, 8'hCC);
    wait_pos(HL - 1, VB);
    chk("req_first_x", req_first, 43);
    chk("req_per_line", req_n, 800);
    iMode = 2'd1;

    wait_pos(0, 0);
    @(negedge iCLK);
    iMode = 2'd3;
    wait_pos(HB + 20, VB);
    chk("ovl_pix", {oLCD_R, oLCD_G, oLCD_B}, 24'h4042E5);

    wait_pos(0, 0);
    @(negedge iCLK);
    wait_pos(0, VB + 1);
    iMode = 2'd2;
    wait_pos(HB + 7, VB + 1);
    chk("solid_mid", {oLCD_R, oLCD_G, oLCD_B}, 24'h123456);

    wait_pos(0, 0);
    @(negedge iCLK);
    wait_pos(HB + 2, VB);
    chk("bar_px0", {oLCD_R, oLCD_G, oLCD_B}, 24'hFFFFFF);
    wait_pos(HB + 101, VB);
    chk("bar_px99", {oLCD_R, oLCD_G, oLCD_B}, 24'hFFFFFF);
    @(negedge iCLK);
    chk("bar_px100", {oLCD_R, oLCD_G, oLCD_B}, 24'hFFFF00);
    wait_pos(HB + 152, VB);
    chk("bar_px150", {oLCD_R, oLCD_G, oLCD_B}, 24'hFFFF00);
    wait_pos(HB + 801, VB);
    chk("bar_px799", {oLCD_R, oLCD_G, oLCD_B}, 24'h000000);

    wait_pos(500, VB + 1);
    iRST_n = 1'b0;
    #1;
    chk("mid_rst_oX", oX, 0);
    chk("mid_rst_oY", oY, 0);
    chk("mid_rst_state", oState, 0);
    chk("mid_rst_cnt", oFrameCnt, 0);
    chk("mid_rst_vd", oVD, 1);
    chk("mid_rst_lcd", {oLCD_R, oLCD_G, oLCD_B}, 0);
    repeat (3) @(negedge iCLK);
    iRST_n = 1'b1;
    chk("rel2_oX", oX, 0);
    chk("rel2_oY", oY, 0);
    repeat (50) @(negedge iCLK);
    chk("post_x", oX, 50);
    chk("post_cnt", oFrameCnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lcd_frame_controller.md
LCD_FRAME_CONTROLLER -- requirements
Module: lcd_frame_controller

Interface
REQ-001 SHALL have parameters (name, default, meaning):
- H_ACTIVE, 800, visible pixels per line
- H_BLANK, 46, hsync plus back porch
- H_FP, 210, horizontal front porch
- V_ACTIVE, 480, visible lines
- V_BLANK, 23, vsync plus back porch
- V_FP, 22, vertical front porch
- PIX_W, 8, bits per colour channel (1..8)
- RD_LAT, 1, SDRAM read latency in cycles (1..4)
REQ-002 SHALL have ports (name, direction, width, meaning):
- iCLK, in, 1, pixel clock
- iRST_n, in, 1, asynchronous active-low reset
- iLoading, in, 1, host loading flag
- iMode, in, 2, 0 SDRAM, 1 overlay, 2 colour bars, 3 solid colour
- iSolid, in, 3*PIX_W, solid colour {R,G,B}
- iREAD_DATA, in, 32, SDRAM pixel; R=[23:16], G=[15:8], B=[7:0], each channel MSB-aligned
- iOVL_DATA, in, 3*PIX_W, overlay pixel for the current oX/oY
- oREAD_SDRAM_EN, out, 1, SDRAM read request
- oX, out, 11, horizontal counter
- oY, out, 10, vertical counter
- oNewFrame, out, 1, frame-start pulse
- oEndFrame, out, 1, last-active-pixel pulse
- oHD, out, 1, horizontal sync
- oVD, out, 1, vertical sync
- oLCD_R, oLCD_G, oLCD_B, out, PIX_W each, colour
- oState, out, 2, 0 NO_DATA, 1 LOADING, 2 RUN
- oFrameCnt, out, 16, completed-frame count

Function
REQ-003 SHALL derive H_LINE=H_BLANK+H_ACTIVE+H_FP and V_LINE=V_BLANK+V_ACTIVE+V_FP.
REQ-004 oX SHALL count 0..H_LINE-1 and wrap to 0; oY SHALL increment when oX wraps and wrap 0 after V_LINE-1.
REQ-005 Active region SHALL be H_BLANK<=oX<H_BLANK+H_ACTIVE and V_BLANK<=oY<V_BLANK+V_ACTIVE.
REQ-006 oNewFrame SHALL be combinational, high when oX=0 and oY=0.
REQ-007 oEndFrame SHALL be combinational, high when oX=H_BLANK+H_ACTIVE-1 and oY=V_BLANK+V_ACTIVE-1.
REQ-008 Sync timing from the counter value:
- oHD low exactly when oX=0
- oVD low exactly when oY=0
REQ-009 oHD, oVD and oLCD_* SHALL be mutually aligned, presenting the counter position that held 2 cycles earlier.
REQ-010 Outside the active region, oLCD_* SHALL be 0.
REQ-011 State machine, evaluated every cycle:
- NO_DATA to LOADING when iLoading=1
- LOADING to RUN when iLoading=0 and oNewFrame=1
- RUN to LOADING when iLoading=1 and oNewFrame=1
- all other cases hold
REQ-012 iMode SHALL be latched only when oNewFrame=1; a mid-frame change SHALL take effect on the next frame.
REQ-013 Colour sources:
- NO_DATA: all channels max (white)
- LOADING: all channels 2^(PIX_W-1) (grey)
- RUN, latched mode selects the source
REQ-014 SDRAM mode: oREAD_SDRAM_EN SHALL be high iff state=RUN, latched mode=0 and (oX+RD_LAT, oY) lies in the active region.
- iREAD_DATA is sampled RD_LAT cycles after each request
- the top PIX_W bits of each channel are used
REQ-015 Overlay mode SHALL register iOVL_DATA with the same alignment as REQ-009.
REQ-016 Colour-bar mode: 8 vertical bars, each floor(H_ACTIVE/8) wide, ordered white, yellow, cyan, green, magenta, red, blue, black. Remainder pixels SHALL be black.
REQ-017 oREAD_SDRAM_EN SHALL be 0 in every mode other than SDRAM.
REQ-018 oFrameCnt SHALL increment by 1 when oNewFrame=1 and wrap from 65535 to 0.

Reset
REQ-019 While iRST_n=0, outputs SHALL hold:
- oX=0, oY=0, oHD=0, oVD=1
- oLCD_*=0, oREAD_SDRAM_EN=0
- oState=NO_DATA, oFrameCnt=0, latched mode=0
REQ-020 Reset asserted mid-frame SHALL abort the frame immediately. After release, counting SHALL restart at oX=0, oY=0 on the first iCLK edge.

Verification
REQ-021 Defaults, iLoading=0 for 2 frames:
- oHD period 1056 cycles, oVD period 554400 cycles
- oLCD_*=255 inside the active region only
- oFrameCnt=2
REQ-022 Pulse iLoading=1 for 10 cycles mid-frame:
- oState=LOADING on the next cycle
- grey 128 output
- RUN at the next oNewFrame
REQ-023 RUN, iMode=0, RD_LAT=3, iREAD_DATA=0x00AABBCC:
- first request at oX=43
- output R=AA, G=BB, B=CC
- exactly 800 requests per active line
REQ-024 RUN, iMode=2: the first active line SHALL show pixels 0-99 white, 100-199 yellow, ..., 700-799 black.
REQ-025 Change iMode 3 to 2 at oY=200: the current frame SHALL stay solid; bars SHALL start from the next frame.
REQ-026 Assert iRST_n=0 at oX=500, oY=300 in RUN; after release, oX=0, oY=0, oState=NO_DATA, oFrameCnt=0.
